// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: two writeback requesters, long-latency issue,
// decode hazard query and the register-file write port.
interface rf_wb_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  i_Req0Valid;
   logic [ADDR_WIDTH-1:0] i_Req0Addr;
   logic [DATA_WIDTH-1:0] i_Req0Data;
   logic                  o_Req0Ready;
   logic                  i_Req1Valid;
   logic [ADDR_WIDTH-1:0] i_Req1Addr;
   logic [DATA_WIDTH-1:0] i_Req1Data;
   logic                  o_Req1Ready;
   logic                  i_IssueEn;
   logic [ADDR_WIDTH-1:0] i_IssueAddr;
   logic [ADDR_WIDTH-1:0] i_Rs1Addr;
   logic [ADDR_WIDTH-1:0] i_Rs2Addr;
   logic [ADDR_WIDTH-1:0] i_RdAddr;
   logic                  o_Stall;
   logic                  o_RegWrEn;
   logic [ADDR_WIDTH-1:0] o_RegWrAddr;
   logic [DATA_WIDTH-1:0] o_RegWrData;

   // Arbiter side
   modport slave (
      input  i_Req0Valid, i_Req0Addr, i_Req0Data,
      input  i_Req1Valid, i_Req1Addr, i_Req1Data,
      input  i_IssueEn, i_IssueAddr, i_Rs1Addr, i_Rs2Addr, i_RdAddr,
      output o_Req0Ready, o_Req1Ready, o_Stall,
      output o_RegWrEn, o_RegWrAddr, o_RegWrData
   );

   // Pipeline / register-file side
   modport master (
      output i_Req0Valid, i_Req0Addr, i_Req0Data,
      output i_Req1Valid, i_Req1Addr, i_Req1Data,
      output i_IssueEn, i_IssueAddr, i_Rs1Addr, i_Rs2Addr, i_RdAddr,
      input  o_Req0Ready, o_Req1Ready, o_Stall,
      input  o_RegWrEn, o_RegWrAddr, o_RegWrData
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback scheduler for the single register-file write port,
// with a pending scoreboard for long-latency destinations and decode stall.
module rf_wb_arbiter #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_NUMBER = 32
) (
   input logic            clk,
   input logic            reset,
   rf_wb_arbiter_if.slave bus
);

   logic                  last_q;
   logic                  grant0_c;
   logic                  grant1_c;
   logic [REG_NUMBER-1:0] pending_q;
   logic [REG_NUMBER-1:0] pending_d;
   logic                  stall_c;
   logic                  wr_en_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;

   // On a tie, grant whoever was not granted last
   always_comb begin
      grant0_c = bus.i_Req0Valid && (!bus.i_Req1Valid || last_q);
      grant1_c = bus.i_Req1Valid && (!bus.i_Req0Valid || !last_q);
   end

   // Scoreboard next state: clear on requester-1 transfer, issue set wins
   always_comb begin
      pending_d = pending_q;
      for (int unsigned i = 1; i < REG_NUMBER; i++) begin
         if (grant1_c && bus.i_Req1Addr == ADDR_WIDTH'(i))
            pending_d[i] = 1'b0;
         if (bus.i_IssueEn && bus.i_IssueAddr == ADDR_WIDTH'(i))
            pending_d[i] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // RAW on either source or WAW on destination against a pending register
   always_comb begin
      stall_c = 1'b0;
      for (int unsigned i = 1; i < REG_NUMBER; i++) begin
         if (pending_q[i] && (bus.i_Rs1Addr == ADDR_WIDTH'(i) ||
                              bus.i_Rs2Addr == ADDR_WIDTH'(i) ||
                              bus.i_RdAddr  == ADDR_WIDTH'(i)))
            stall_c = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q    <= 1'b1;
         pending_q <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         pending_q <= pending_d;
         if (grant0_c) begin
            last_q    <= 1'b0;
            wr_en_q   <= (bus.i_Req0Addr != '0);
            wr_addr_q <= bus.i_Req0Addr;
            wr_data_q <= bus.i_Req0Data;
         end else if (grant1_c) begin
            last_q    <= 1'b1;
            wr_en_q   <= (bus.i_Req1Addr != '0);
            wr_addr_q <= bus.i_Req1Addr;
            wr_data_q <= bus.i_Req1Data;
         end else begin
            wr_en_q   <= 1'b0;
         end
      end
   end

   assign bus.o_Req0Ready = grant0_c;
   assign bus.o_Req1Ready = grant1_c;
   assign bus.o_Stall     = stall_c;
   assign bus.o_RegWrEn   = wr_en_q;
   assign bus.o_RegWrAddr = wr_addr_q;
   assign bus.o_RegWrData = wr_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: per-cycle comparison against a behavioural model
// plus directed scenarios with literal expectations.
module tb_rf_wb_arbiter;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned NR = 32;

   logic clk = 1'b0;
   logic reset;

   rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_NUMBER(NR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
   endtask

   // Behavioural model: who was served most recently, which registers
   // still await a long-latency result, and what the write port shows.
   bit          m_pending [NR];
   int          m_recent = 1;
   bit          m_wr_en = 0;
   int unsigned m_wr_addr = 0;
   logic [31:0] m_wr_data = '0;
   bit          live = 0;

   function automatic int winner();
      if (bus.i_Req0Valid && bus.i_Req1Valid) return (m_recent == 0) ? 1 : 0;
      if (bus.i_Req0Valid) return 0;
      if (bus.i_Req1Valid) return 1;
      return -1;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (live) begin
            int w;
            bit st;
            w  = winner();
            st = m_pending[bus.i_Rs1Addr] || m_pending[bus.i_Rs2Addr] || m_pending[bus.i_RdAddr];
            chk("model_ready0", 32'(bus.o_Req0Ready), 32'(w == 0));
            chk("model_ready1", 32'(bus.o_Req1Ready), 32'(w == 1));
            chk("model_stall",  32'(bus.o_Stall),     32'(st));
            chk("model_wr_en",  32'(bus.o_RegWrEn),   32'(m_wr_en));
            chk("model_wr_addr",32'(bus.o_RegWrAddr), m_wr_addr);
            chk("model_wr_data",bus.o_RegWrData,      m_wr_data);
         end
         @(posedge clk);
         if (reset) begin
            foreach (m_pending[i]) m_pending[i] = 0;
            m_recent = 1; m_wr_en = 0; m_wr_addr = 0; m_wr_data = '0;
            live = 1;
         end else if (live) begin
            int w;
            w = winner();
            m_wr_en = 0;
            if (w == 0) begin
               m_wr_addr = bus.i_Req0Addr; m_wr_data = bus.i_Req0Data;
               m_wr_en = (bus.i_Req0Addr != 0);
            end else if (w == 1) begin
               m_wr_addr = bus.i_Req1Addr; m_wr_data = bus.i_Req1Data;
               m_wr_en = (bus.i_Req1Addr != 0);
               m_pending[bus.i_Req1Addr] = 0;
            end
            if (w >= 0) m_recent = w;
            if (bus.i_IssueEn && bus.i_IssueAddr != 0) m_pending[bus.i_IssueAddr] = 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_Req0Valid = 0; bus.i_Req0Addr = '0; bus.i_Req0Data = '0;
      bus.i_Req1Valid = 0; bus.i_Req1Addr = '0; bus.i_Req1Data = '0;
      bus.i_IssueEn = 0;   bus.i_IssueAddr = '0;
      bus.i_Rs1Addr = '0;  bus.i_Rs2Addr = '0;  bus.i_RdAddr = '0;
   endtask

   task automatic do_reset();
      reset = 1;
      tick(); tick();
      reset = 0;
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_wr_en", 32'(bus.o_RegWrEn), 32'd0);
      chk("rst_wr_addr", 32'(bus.o_RegWrAddr), 32'd0);
      chk("rst_wr_data", bus.o_RegWrData, 32'd0);
      chk("rst_stall", 32'(bus.o_Stall), 32'd0);

      // Single requester 0 transfer
      tick();
      bus.i_Req0Valid = 1; bus.i_Req0Addr = 5'd5; bus.i_Req0Data = 32'hDEADBEEF;
      @(negedge clk);
      chk("t1_ready0", 32'(bus.o_Req0Ready), 32'd1);
      tick();
      bus.i_Req0Valid = 0;
      @(negedge clk);
      chk("t1_wr_en", 32'(bus.o_RegWrEn), 32'd1);
      chk("t1_wr_addr", 32'(bus.o_RegWrAddr), 32'd5);
      chk("t1_wr_data", bus.o_RegWrData, 32'hDEADBEEF);
      tick();
      @(negedge clk);
      chk("t1_wr_en_off", 32'(bus.o_RegWrEn), 32'd0);

      // Continuous tie after reset: grants 0,1,0,1
      do_reset();
      bus.i_Req0Valid = 1; bus.i_Req0Addr = 5'd1; bus.i_Req0Data = 32'h11;
      bus.i_Req1Valid = 1; bus.i_Req1Addr = 5'd2; bus.i_Req1Data = 32'h22;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t2_ready0", 32'(bus.o_Req0Ready), 32'((k % 2) == 0));
         chk("t2_ready1", 32'(bus.o_Req1Ready), 32'((k % 2) == 1));
         if (k > 0) chk("t2_wr_addr", 32'(bus.o_RegWrAddr), ((k - 1) % 2 == 0) ? 32'd1 : 32'd2);
         tick();
      end
      bus.i_Req0Valid = 0; bus.i_Req1Valid = 0;
      @(negedge clk);
      chk("t2_last_wr_addr", 32'(bus.o_RegWrAddr), 32'd2);
      chk("t2_last_wr_data", bus.o_RegWrData, 32'h22);
      tick();

      // Issue to x7, RAW stall on rs2, released by requester-1 writeback
      bus.i_IssueEn = 1; bus.i_IssueAddr = 5'd7; bus.i_Rs2Addr = 5'd7;
      @(negedge clk);
      chk("t3_stall_issue_cycle", 32'(bus.o_Stall), 32'd0);
      tick();
      bus.i_IssueEn = 0;
      @(negedge clk);
      chk("t3_stall_set", 32'(bus.o_Stall), 32'd1);
      tick();
      bus.i_Req1Valid = 1; bus.i_Req1Addr = 5'd7; bus.i_Req1Data = 32'h55;
      @(negedge clk);
      chk("t3_ready1", 32'(bus.o_Req1Ready), 32'd1);
      chk("t3_stall_hold", 32'(bus.o_Stall), 32'd1);
      tick();
      bus.i_Req1Valid = 0;
      @(negedge clk);
      chk("t3_stall_release", 32'(bus.o_Stall), 32'd0);
      chk("t3_wr_en", 32'(bus.o_RegWrEn), 32'd1);
      chk("t3_wr_addr", 32'(bus.o_RegWrAddr), 32'd7);
      chk("t3_wr_data", bus.o_RegWrData, 32'h55);
      tick();
      bus.i_Rs2Addr = '0;

      // x0: transfer consumed without a write, issue never stalls
      bus.i_Req0Valid = 1; bus.i_Req0Addr = 5'd0; bus.i_Req0Data = 32'h1234;
      @(negedge clk);
      chk("t4_ready0", 32'(bus.o_Req0Ready), 32'd1);
      tick();
      bus.i_Req0Valid = 0;
      bus.i_IssueEn = 1; bus.i_IssueAddr = 5'd0;
      @(negedge clk);
      chk("t4_wr_en_x0", 32'(bus.o_RegWrEn), 32'd0);
      tick();
      bus.i_IssueEn = 0;
      @(negedge clk);
      chk("t4_stall_x0", 32'(bus.o_Stall), 32'd0);
      tick();

      // Same-edge issue and requester-1 clear of x9: set wins
      bus.i_IssueEn = 1; bus.i_IssueAddr = 5'd9;
      bus.i_Req1Valid = 1; bus.i_Req1Addr = 5'd9; bus.i_Req1Data = 32'h99;
      bus.i_RdAddr = 5'd9;
      @(negedge clk);
      chk("t5_ready1", 32'(bus.o_Req1Ready), 32'd1);
      tick();
      bus.i_IssueEn = 0; bus.i_Req1Valid = 0;
      @(negedge clk);
      chk("t5_stall_rd9", 32'(bus.o_Stall), 32'd1);
      tick();
      bus.i_RdAddr = '0;

      // Reset drops an in-flight requester-1 transfer and the scoreboard
      bus.i_IssueEn = 1; bus.i_IssueAddr = 5'd3;
      tick();
      bus.i_IssueEn = 0; bus.i_Rs1Addr = 5'd3;
      @(negedge clk);
      chk("t6_stall_pre", 32'(bus.o_Stall), 32'd1);
      tick();
      reset = 1;
      bus.i_Req1Valid = 1; bus.i_Req1Addr = 5'd3; bus.i_Req1Data = 32'h33;
      @(negedge clk);
      chk("t6_ready1_in_reset", 32'(bus.o_Req1Ready), 32'd1);
      tick();
      reset = 0; bus.i_Req1Valid = 0;
      @(negedge clk);
      chk("t6_no_write", 32'(bus.o_RegWrEn), 32'd0);
      chk("t6_stall_cleared", 32'(bus.o_Stall), 32'd0);
      tick();
      bus.i_Req0Valid = 1; bus.i_Req0Addr = 5'd4; bus.i_Req0Data = 32'h44;
      bus.i_Req1Valid = 1; bus.i_Req1Addr = 5'd6; bus.i_Req1Data = 32'h66;
      @(negedge clk);
      chk("t6_tie_ready0", 32'(bus.o_Req0Ready), 32'd1);
      chk("t6_tie_ready1", 32'(bus.o_Req1Ready), 32'd0);
      tick();
      idle_inputs();
      @(negedge clk);
      chk("t6_wr_addr", 32'(bus.o_RegWrAddr), 32'd4);
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback scheduler for the single write port of the integer register file. It arbitrates round-robin between two writeback requesters: requester 0 is the pipeline writeback and requester 1 is the long-latency unit (load/multi-cycle). It drives the write port from a registered stage. It also keeps a per-register pending scoreboard for long-latency results and raises a stall to the decode stage on RAW/WAW hazards against them.

## Interface
- ADDR_WIDTH, 5, register address width
- DATA_WIDTH, 32, register data width
- REG_NUMBER, 32, number of architectural registers (x0 hardwired zero)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- i_Req0Valid  in  1  requester 0 has a result
- i_Req0Addr  in  ADDR_WIDTH  requester 0 destination register
- i_Req0Data  in  DATA_WIDTH  requester 0 result
- o_Req0Ready  out  1  requester 0 accepted this cycle
- i_Req1Valid / i_Req1Addr / i_Req1Data / o_Req1Ready  same as requester 0, for requester 1
- i_IssueEn  in  1  a long-latency op targeting i_IssueAddr is issued this cycle
- i_IssueAddr  in  ADDR_WIDTH  destination of issued long-latency op
- i_Rs1Addr, i_Rs2Addr, i_RdAddr  in  ADDR_WIDTH  decode-stage source/destination registers
- o_Stall  out  1  decode must hold (hazard on a pending register)
- o_RegWrEn  out  1  register-file write enable
- o_RegWrAddr  out  ADDR_WIDTH  register-file write address
- o_RegWrData  out  DATA_WIDTH  register-file write data

## Operation
- Handshake: a requester holds Valid, Addr and Data stable until Ready. A transfer occurs in a cycle with Valid && Ready. Ready is combinational from the Valid inputs and the priority pointer, and is never asserted without Valid.
- Arbitration: at most one grant per cycle.
  - One valid requester: it is granted.
  - Both valid: the requester not granted most recently is granted.
  - Priority pointer `last` (1 bit) updates to the granted index on every grant. Reset value is 1, so requester 0 wins the first tie.
- Write stage (registered). On a grant at edge N:
  - o_RegWrAddr and o_RegWrData are loaded with the granted Addr and Data.
  - o_RegWrEn = 1 for cycle N+1 if Addr != 0.
  - A transfer to x0 is accepted and consumed, but o_RegWrEn stays 0.
  - With no grant, o_RegWrEn = 0; Addr and Data hold their previous values.
- Scoreboard: `pending[REG_NUMBER-1:0]`; bit 0 is constant 0.
  - Set: i_IssueEn && i_IssueAddr != 0 sets pending[i_IssueAddr].
  - Clear: a requester-1 transfer clears pending[i_Req1Addr]. Requester-0 transfers never touch the scoreboard.
  - Same edge, same address, set and clear: set wins.
- o_Stall is combinational: pending[i_Rs1Addr] | pending[i_Rs2Addr] | pending[i_RdAddr]. Bit 0 is constant 0, so x0 never stalls.
- Issuing to an already-pending register is a protocol violation. Decode is prevented from doing so by the WAW term in o_Stall. If it happens anyway, the bit stays set and is cleared by the first matching requester-1 transfer.

## Timing
- Reset (synchronous, dominant over all other inputs):
  - pending = 0, last = 1, o_RegWrEn = 0, o_RegWrAddr = 0, o_RegWrData = 0.
  - o_Stall = 0 and o_ReqXReady follow combinationally from the cleared state.
- Reset mid-operation: any transfer accepted in the reset cycle is dropped (no write follows). All pending bits are lost.
- Accept-to-write latency: exactly 1 cycle. Throughput: one write per cycle.
- Stall release: o_Stall deasserts in cycle N+1 after a requester-1 transfer at edge N. In that cycle o_RegWrEn presents the value, and the register file's write-through bypass supplies it to decode.
- Starvation bound: a requester holding Valid is granted within 2 cycles.
- Issue in cycle N: o_Stall for that register rises in cycle N+1.

## Test plan
- Reset, then assert only Req0 (addr 5, data 0xDEADBEEF) for 1 cycle -> o_Req0Ready=1 same cycle; next cycle o_RegWrEn=1, o_RegWrAddr=5, o_RegWrData=0xDEADBEEF; the cycle after, o_RegWrEn=0.
- Both requesters valid continuously for 4 cycles (Req0 addr 1, Req1 addr 2) -> grants alternate 0,1,0,1; o_RegWrAddr sequence 1,2,1,2 with 1-cycle lag.
- Issue to x7, then decode i_Rs2Addr=7 -> o_Stall=1 from next cycle. Req1 writes x7 = 0x55 -> o_Stall=0 in the cycle o_RegWrEn=1 with addr 7.
- Req0 transfer to x0 with data 0x1234 -> o_Req0Ready=1, o_RegWrEn stays 0. Issue to x0 -> o_Stall never asserts for x0.
- Same-edge issue and Req1 transfer both to x9 -> pending[9] remains set and o_Stall=1 for i_RdAddr=9.
- Req1 accepted while reset is high, with x3 pending -> no write in the following cycle, o_Stall=0 for x3, next tie granted to Req0.
